synchro_counter_param: RTL and testbench

SYNCHRO_COUNTER_PARAM -- requirements
Module: synchro_counter_param

---
 rtl/synchro_counter_param.sv | 108 ++++++++++
 tb/tb_synchro_counter_param.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/synchro_counter_param.sv
// Modulo up/down counter advanced by rising edges of the clk_in strobe, clocked by qzt_clk.
// Define SYNCHRO_COUNTER_INPUT_SYNC_EN to pass clk_in through a two-flop synchroniser first.
module synchro_counter_param #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             qzt_clk,
  input  logic             reset_n,
  input  logic             clk_in,
  input  logic             set,
  input  logic [WIDTH-1:0] preset_value,
  input  logic [WIDTH-1:0] limit,
  input  logic             direction,
  input  logic             saturate,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             borrow
);

  logic             strobe;
  logic             clk_in_old_q;
  logic             count_evt;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;

`ifdef SYNCHRO_COUNTER_INPUT_SYNC_EN
  logic sync1_q, sync2_q;

  // Stages reset high so a strobe held high across reset release is not an edge.
  always_ff @(posedge qzt_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= clk_in;
      sync2_q <= sync1_q;
    end
  end

  assign strobe = sync2_q;
`else
  assign strobe = clk_in;
`endif

  always_ff @(posedge qzt_clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_in_old_q <= 1'b1;
    end else begin
      clk_in_old_q <= strobe;
    end
  end

  assign count_evt = strobe & ~clk_in_old_q;

  // limit of zero selects the full 2^WIDTH range.
  assign top = (limit == '0) ? {WIDTH{1'b1}} : (limit - WIDTH'(1));

  // Next-state: set beats a count event, which beats hold.
  always_comb begin
    out_d    = out_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (set) begin
      out_d = preset_value;
    end else if (count_evt) begin
      if (direction) begin
        if (out_q >= top) begin
          if (saturate) begin
            out_d = top;
          end else begin
            out_d   = '0;
            carry_d = 1'b1;
          end
        end else begin
          out_d = out_q + WIDTH'(1);
        end
      end else begin
        if (out_q == '0) begin
          if (!saturate) begin
            out_d    = top;
            borrow_d = 1'b1;
          end
        end else begin
          out_d = out_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge qzt_clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q    <= WIDTH'(RESET_VALUE);
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign out    = out_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_synchro_counter_param.sv
// Directed bench for synchro_counter_param (WIDTH=8, RESET_VALUE=3); inputs driven and outputs sampled on negedge.
module tb_synchro_counter_param;

  localparam int unsigned WIDTH = 8;
`ifdef SYNCHRO_COUNTER_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic             qzt_clk = 1'b0;
  logic             reset_n;
  logic             clk_in;
  logic             set;
  logic [WIDTH-1:0] preset_value;
  logic [WIDTH-1:0] limit;
  logic             direction;
  logic             saturate;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             borrow;

  int checks = 0;
  int errors = 0;

  synchro_counter_param #(.WIDTH(WIDTH), .RESET_VALUE(3)) dut (
    .qzt_clk      (qzt_clk),
    .reset_n      (reset_n),
    .clk_in       (clk_in),
    .set          (set),
    .preset_value (preset_value),
    .limit        (limit),
    .direction    (direction),
    .saturate     (saturate),
    .out          (out),
    .carry        (carry),
    .borrow       (borrow)
  );

  always #5 qzt_clk = ~qzt_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clk_in pulse; check the result once it has propagated, then check the flags drop.
  task automatic pulse(input string tag, input int exp_out, input bit exp_c, input bit exp_b);
    clk_in = 1'b1;
    @(negedge qzt_clk);
    clk_in = 1'b0;
    repeat (LAT - 1) @(negedge qzt_clk);
    check({tag, "_out"}, 32'(out), 32'(exp_out));
    check({tag, "_cb"}, {30'd0, carry, borrow}, {30'd0, exp_c, exp_b});
    @(negedge qzt_clk);
    check({tag, "_cb_drop"}, {30'd0, carry, borrow}, 32'd0);
  endtask

  task automatic load(input string tag, input int v);
    set          = 1'b1;
    preset_value = WIDTH'(v);
    @(negedge qzt_clk);
    set = 1'b0;
    check({tag, "_load"}, 32'(out), 32'(v));
    check({tag, "_load_cb"}, {30'd0, carry, borrow}, 32'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    clk_in       = 1'b0;
    set          = 1'b0;
    preset_value = '0;
    limit        = 8'd10;
    direction    = 1'b1;
    saturate     = 1'b0;
    @(negedge qzt_clk);
    check("reset_out", 32'(out), 32'd3);
    check("reset_cb", {30'd0, carry, borrow}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge qzt_clk);
    check("idle_out", 32'(out), 32'd3);

    // Modulo-10 up count with one wrap.
    load("m10", 0);
    for (int i = 1; i <= 12; i++) begin
      pulse($sformatf("m10_p%0d", i), i % 10, (i == 10), 1'b0);
    end

    // Full-range down wrap, then saturating hold at zero.
    limit = 8'd0; direction = 1'b0;
    load("full", 0);
    pulse("full_dn_wrap", 255, 1'b0, 1'b1);
    saturate = 1'b1;
    load("full_sat", 0);
    pulse("full_dn_sat", 0, 1'b0, 1'b0);

    // Preset above top.
    limit = 8'd10; direction = 1'b1; saturate = 1'b0;
    load("above", 50);
    pulse("above_up_wrap", 0, 1'b1, 1'b0);
    load("above2", 50);
    direction = 1'b0;
    pulse("above_dn", 49, 1'b0, 1'b0);
    direction = 1'b1; saturate = 1'b1;
    load("above3", 50);
    pulse("above_up_sat", 9, 1'b0, 1'b0);
    pulse("top_up_sat", 9, 1'b0, 1'b0);

    // Set coincident with a strobe edge: the edge is discarded.
    saturate = 1'b0;
    load("coin_pre", 2);
    set = 1'b1; preset_value = 8'd7; clk_in = 1'b1;
    @(negedge qzt_clk);
    clk_in = 1'b0;
    repeat (LAT - 1) @(negedge qzt_clk);
    set = 1'b0;
    check("coin_out", 32'(out), 32'd7);
    check("coin_cb", {30'd0, carry, borrow}, 32'd0);
    repeat (LAT + 1) @(negedge qzt_clk);
    check("coin_hold", 32'(out), 32'd7);

    // Asynchronous reset between edges, strobe held high through release.
    load("rst_pre", 5);
    #2 reset_n = 1'b0;
    #1 check("async_rst_out", 32'(out), 32'd3);
    clk_in = 1'b1;
    repeat (2) @(negedge qzt_clk);
    reset_n = 1'b1;
    repeat (LAT + 2) @(negedge qzt_clk);
    check("rel_no_count", 32'(out), 32'd3);
    check("rel_cb", {30'd0, carry, borrow}, 32'd0);
    clk_in = 1'b0;
    @(negedge qzt_clk);
    pulse("rel_first", 4, 1'b0, 1'b0);

    // Shrinking limit alters nothing until the next event.
    limit = 8'd5;
    repeat (3) @(negedge qzt_clk);
    check("lim_chg_hold", 32'(out), 32'd4);
    pulse("lim_chg_wrap", 0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
